mux4_rr_arbiter: RTL and testbench

//   Round-robin arbiter that drives the 2-bit select of the 4:1 channel mux (mux4).

---
 rtl/mux4_rr_arbiter.sv | 93 +++++++++
 tb/tb_mux4_rr_arbiter.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter driving the 2-bit select of a 4:1 channel mux, with a per-grant burst limit.
// Optional feature: define RR_LOCK_EN to add a lock input that suppresses the burst-limit release.
module mux4_rr_arbiter #(
  parameter int unsigned MAX_BURST = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  input  logic       ready,
`ifdef RR_LOCK_EN
  input  logic       lock,
`endif
  output logic [1:0] sel,
  output logic [3:0] grant,
  output logic       gnt_valid,
  output logic [3:0] beat_cnt
);

  typedef enum logic {IDLE, GRANT} state_t;

  localparam logic [3:0] LAST_BEAT = 4'(MAX_BURST - 1);

  state_t     state;
  logic [1:0] last;
  logic [1:0] pick;
  logic [1:0] idx;
  logic       found;
  logic       lock_act;
  logic       at_limit;
  logic       release_now;

`ifdef RR_LOCK_EN
  always_comb lock_act = lock;
`else
  always_comb lock_act = 1'b0;
`endif

  // Scan last+1 .. last+4 (mod 4); the previous owner is visited last.
  always_comb begin
    pick  = '0;
    idx   = '0;
    found = 1'b0;
    for (int unsigned k = 1; k <= 4; k++) begin
      idx = last + 2'(k);
      if (!found && req[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
  end

  always_comb begin
    at_limit    = (beat_cnt == LAST_BEAT);
    release_now = !req[sel] || (ready && at_limit && !lock_act);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      last      <= 2'd3;
      sel       <= '0;
      grant     <= '0;
      gnt_valid <= 1'b0;
      beat_cnt  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            sel       <= pick;
            grant     <= 4'b0001 << pick;
            gnt_valid <= 1'b1;
            beat_cnt  <= '0;
            state     <= GRANT;
          end
        end
        GRANT: begin
          if (release_now) begin
            last      <= sel;
            grant     <= '0;
            gnt_valid <= 1'b0;
            beat_cnt  <= '0;
            state     <= IDLE;
          end else if (ready && !at_limit) begin
            // At the limit here only when locked: the count saturates.
            beat_cnt <= beat_cnt + 4'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Scoreboard bench for mux4_rr_arbiter: directed scenarios followed by random traffic.
module tb_mux4_rr_arbiter;

  localparam int MAX_BURST = 4;
`ifdef RR_LOCK_EN
  localparam bit LOCK_EN = 1'b1;
`else
  localparam bit LOCK_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic       ready;
`ifdef RR_LOCK_EN
  logic       lock;
`endif
  logic [1:0] sel;
  logic [3:0] grant;
  logic       gnt_valid;
  logic [3:0] beat_cnt;

  mux4_rr_arbiter #(.MAX_BURST(MAX_BURST)) dut (
    .clk(clk),
    .rst(rst),
    .req(req),
    .ready(ready),
`ifdef RR_LOCK_EN
    .lock(lock),
`endif
    .sel(sel),
    .grant(grant),
    .gnt_valid(gnt_valid),
    .beat_cnt(beat_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] sel;
    logic [3:0] grant;
    logic       gv;
    logic [3:0] bc;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;
  bit   done     = 1'b0;

  // Reference model: which channel owns the mux, how many beats it has moved,
  // and who owned it last.
  int owner = -1;
  int beats = 0;
  int mlast = 3;
  int msel  = 0;

  task automatic model_release();
    mlast = owner;
    owner = -1;
    beats = 0;
  endtask

  task automatic model_update(input logic r, input logic [3:0] rq, input logic rd, input logic lk);
    if (r) begin
      owner = -1; beats = 0; mlast = 3; msel = 0;
    end else if (owner < 0) begin
      for (int k = 1; k <= 4; k++) begin
        int c;
        c = (mlast + k) % 4;
        if (owner < 0 && rq[c]) begin
          owner = c; msel = c; beats = 0;
        end
      end
    end else if (!rq[owner]) begin
      model_release();
    end else if (rd) begin
      if (beats + 1 >= MAX_BURST) begin
        if (lk) beats = MAX_BURST - 1;
        else    model_release();
      end else begin
        beats = beats + 1;
      end
    end
  endtask

  task automatic step(input logic r, input logic [3:0] rq, input logic rd, input logic lk);
    exp_t e;
    rst = r; req = rq; ready = rd;
`ifdef RR_LOCK_EN
    lock = lk;
`endif
    model_update(r, rq, rd, lk && LOCK_EN);
    e.sel   = 2'(msel);
    e.grant = (owner >= 0) ? (4'b0001 << owner) : 4'b0000;
    e.gv    = (owner >= 0);
    e.bc    = 4'(beats);
    sb.push_back(e);
    @(negedge clk);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Monitor: compare every cycle's outputs against the oldest queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() == 0) begin
        if (!done) chk("sb_empty", 32'd0, 32'd1);
      end else begin
        e = sb.pop_front();
        chk("gnt_valid", 32'(gnt_valid), 32'(e.gv));
        chk("grant",     32'(grant),     32'(e.grant));
        chk("sel",       32'(sel),       32'(e.sel));
        chk("beat_cnt",  32'(beat_cnt),  32'(e.bc));
        chk("grant_inv", 32'(grant), gnt_valid ? 32'(4'b0001 << sel) : 32'd0);
      end
    end
  end

  initial begin
    rst = 1'b1; req = '0; ready = 1'b0;
`ifdef RR_LOCK_EN
    lock = 1'b0;
`endif
    // Reset, then idle
    step(1, 4'b0000, 0, 0);
    step(1, 4'b0000, 0, 0);
    repeat (3) step(0, 4'b0000, 0, 0);
    // All request, ready held: rotating 4-beat grants with bubbles
    repeat (26) step(0, 4'b1111, 1, 0);
    step(0, 4'b0000, 0, 0);
    step(0, 4'b0000, 0, 0);
    // Stall on ch2, then drain
    repeat (5) step(0, 4'b0100, 0, 0);
    repeat (6) step(0, 4'b0100, 1, 0);
    step(0, 4'b0000, 0, 0);
    // ch1 to beat 2, drop req[1] while stalled, ch3 wins next
    step(0, 4'b0010, 1, 0);
    step(0, 4'b0010, 1, 0);
    step(0, 4'b0010, 1, 0);
    step(0, 4'b1010, 0, 0);
    step(0, 4'b1000, 0, 0);
    step(0, 4'b1000, 0, 0);
    step(0, 4'b1010, 0, 0);
    repeat (2) step(0, 4'b1010, 1, 0);
    step(0, 4'b0000, 0, 0);
    step(0, 4'b0000, 0, 0);
    // Reset mid-burst on ch2, then ch0 first
    step(0, 4'b0100, 1, 0);
    step(0, 4'b0100, 1, 0);
    step(1, 4'b0100, 1, 0);
    repeat (4) step(0, 4'b1111, 1, 0);
    step(0, 4'b0000, 0, 0);
    step(0, 4'b0000, 0, 0);
    // Lock on a single requester, then drop lock
    repeat (10) step(0, 4'b0001, 1, 1);
    repeat (4) step(0, 4'b0001, 1, 0);
    step(0, 4'b0000, 0, 0);
    // Random traffic
    for (int i = 0; i < 1500; i++) begin
      step(($urandom_range(0, 63) == 0), 4'($urandom), ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 3) == 0));
    end
    done = 1'b1;
    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
